// File: rtl/dcontact_collector_pkg.sv
// -----------------------------------------------------------------------------
// dcontact_collector_pkg
// Shared definitions for the contact collector: record width, the fixed field
// order of a packed contact record, bit offsets of each field inside the
// 288-bit record, and a single-precision 1.0 constant for benches.
// Ports: none (package).
// -----------------------------------------------------------------------------
package dcontact_collector_pkg;

  localparam int FIELD_W   = 32;
  localparam int CONTACT_W = 9 * FIELD_W;  // 288

  // Field order, most significant first: cx cy cz nx ny nz depth g1 g2
  localparam int CX_OFF    = 8 * FIELD_W;
  localparam int CY_OFF    = 7 * FIELD_W;
  localparam int CZ_OFF    = 6 * FIELD_W;
  localparam int NX_OFF    = 5 * FIELD_W;
  localparam int NY_OFF    = 4 * FIELD_W;
  localparam int NZ_OFF    = 3 * FIELD_W;
  localparam int DEPTH_OFF = 2 * FIELD_W;
  localparam int G1_OFF    = 1 * FIELD_W;
  localparam int G2_OFF    = 0;

  localparam logic [31:0] FP_ONE = 32'h3F80_0000;

  // Packed member order matches the offsets above (first member = MSBs).
  typedef struct packed {
    logic [31:0] cx;
    logic [31:0] cy;
    logic [31:0] cz;
    logic [31:0] nx;
    logic [31:0] ny;
    logic [31:0] nz;
    logic [31:0] depth;
    logic [31:0] g1;
    logic [31:0] g2;
  } contact_t;

  // Builds a record from individual fields in the canonical order.
  function automatic contact_t pack_contact(
    input logic [31:0] cx, input logic [31:0] cy, input logic [31:0] cz,
    input logic [31:0] nx, input logic [31:0] ny, input logic [31:0] nz,
    input logic [31:0] depth, input logic [31:0] g1, input logic [31:0] g2);
    contact_t c;
    c.cx    = cx;
    c.cy    = cy;
    c.cz    = cz;
    c.nx    = nx;
    c.ny    = ny;
    c.nz    = nz;
    c.depth = depth;
    c.g1    = g1;
    c.g2    = g2;
    return c;
  endfunction

endpackage

// File: rtl/dcontact_collector_if.sv
// -----------------------------------------------------------------------------
// dcontact_collector_if
// Record stream from the collector to the host-side consumer: the head record
// fields, its valid strobe and the consumer's accept.
// Modports:
//   master - collector side: drives out_* fields and out_stb, reads out_ack.
//   slave  - consumer side: reads out_* fields and out_stb, drives out_ack.
// -----------------------------------------------------------------------------
interface dcontact_collector_if;

  logic [31:0] out_cx;
  logic [31:0] out_cy;
  logic [31:0] out_cz;
  logic [31:0] out_nx;
  logic [31:0] out_ny;
  logic [31:0] out_nz;
  logic [31:0] out_depth;
  logic [31:0] out_g1;
  logic [31:0] out_g2;
  logic        out_stb;
  logic        out_ack;

  modport master (
    output out_cx, out_cy, out_cz, out_nx, out_ny, out_nz,
           out_depth, out_g1, out_g2, out_stb,
    input  out_ack
  );

  modport slave (
    input  out_cx, out_cy, out_cz, out_nx, out_ny, out_nz,
           out_depth, out_g1, out_g2, out_stb,
    output out_ack
  );

endinterface

// File: rtl/dcontact_fifo_mem.sv
// -----------------------------------------------------------------------------
// dcontact_fifo_mem
// DEPTH x W register array for contact records: one synchronous write port and
// one asynchronous (combinational) read port. No reset; validity of entries is
// tracked by the owner's count.
// Ports:
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out read data (entry at raddr, combinational)
// -----------------------------------------------------------------------------
module dcontact_fifo_mem #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int W      = 288
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dcontact_collector.sv
// -----------------------------------------------------------------------------
// dcontact_collector
// Captures each new collider result: results with ret=1 are pushed as one
// 288-bit contact record into a show-ahead FIFO drained over a strobe/ack
// handshake; results with ret=0 and contacts lost to a full FIFO are counted
// in saturating counters.
// Ports:
//   clk          in  system clock
//   rst          in  asynchronous active-low reset
//   clear        in  synchronous clear of FIFO, counters and overflow
//   in_done      in  collider done level (one event per rising edge)
//   in_ret       in  collider ret, 1 = contact produced
//   in_cx..in_g2 in  contact fields, stored bit-exact
//   rec          if  master side of the record stream (out_* / out_stb / out_ack)
//   count        out records held, 0..DEPTH
//   overflow     out sticky, a contact was dropped while full
//   miss_count   out saturating count of ret=0 results
//   drop_count   out saturating count of dropped contacts
// -----------------------------------------------------------------------------
module dcontact_collector
  import dcontact_collector_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_done,
  input  logic                  in_ret,
  input  logic [31:0]           in_cx,
  input  logic [31:0]           in_cy,
  input  logic [31:0]           in_cz,
  input  logic [31:0]           in_nx,
  input  logic [31:0]           in_ny,
  input  logic [31:0]           in_nz,
  input  logic [31:0]           in_depth,
  input  logic [31:0]           in_g1,
  input  logic [31:0]           in_g2,
  dcontact_collector_if.master  rec,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  output logic [CNT_W-1:0]      miss_count,
  output logic [CNT_W-1:0]      drop_count
);

  localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic              done_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              new_result;
  logic              push_req;
  logic              pop_ok;
  logic              push_ok;
  logic              drop;
  logic              miss;
  logic              full;
  logic              stb;
  contact_t          wr_rec;
  contact_t          rd_rec;
  contact_t          head;
  contact_t          hold_q;
  logic [CONTACT_W-1:0] rd_raw;

  // Rising edge of done marks a new result; clear swallows it entirely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= in_done;
    end
  end

  assign new_result = in_done & ~done_q;
  assign full       = (count == FULL_CNT);
  assign stb        = (count != '0);

  always_comb begin
    push_req = new_result & in_ret & ~clear;
    miss     = new_result & ~in_ret & ~clear;
    // A pop is only meaningful when a head record is actually presented.
    pop_ok   = stb & rec.out_ack & ~clear;
    // When full, a same-cycle pop frees the slot the push is about to use.
    push_ok  = push_req & (~full | pop_ok);
    drop     = push_req & full & ~pop_ok;
  end

  assign wr_rec = pack_contact(in_cx, in_cy, in_cz, in_nx, in_ny, in_nz,
                               in_depth, in_g1, in_g2);

  dcontact_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .W      (CONTACT_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (wr_rec),
    .raddr (rd_ptr),
    .rdata (rd_raw)
  );

  assign rd_rec = contact_t'(rd_raw);

  // Pointers wrap naturally (DEPTH is a power of two); occupancy comes from
  // count alone so full and empty are never confused at wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow   <= 1'b0;
      miss_count <= '0;
      drop_count <= '0;
    end else if (clear) begin
      overflow   <= 1'b0;
      miss_count <= '0;
      drop_count <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != CNT_MAX) begin
          drop_count <= drop_count + 1'b1;
        end
      end
      if (miss && (miss_count != CNT_MAX)) begin
        miss_count <= miss_count + 1'b1;
      end
    end
  end

  // When the FIFO is empty the slot at rd_ptr holds stale data, so the last
  // value shown is kept in hold_q and presented instead. Reset zeroes it,
  // which also gives all-zero outputs while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= head;
    end
  end

  assign head = stb ? rd_rec : hold_q;

  assign rec.out_stb   = stb;
  assign rec.out_cx    = head.cx;
  assign rec.out_cy    = head.cy;
  assign rec.out_cz    = head.cz;
  assign rec.out_nx    = head.nx;
  assign rec.out_ny    = head.ny;
  assign rec.out_nz    = head.nz;
  assign rec.out_depth = head.depth;
  assign rec.out_g1    = head.g1;
  assign rec.out_g2    = head.g2;

endmodule

// File: tb/tb_dcontact_collector.sv
// -----------------------------------------------------------------------------
// tb_dcontact_collector
// Directed self-checking bench for dcontact_collector. Inputs are driven and
// outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dcontact_collector;
  import dcontact_collector_pkg::*;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        in_done;
  logic        in_ret;
  logic [31:0] in_cx, in_cy, in_cz, in_nx, in_ny, in_nz, in_depth, in_g1, in_g2;
  logic [3:0]  count;
  logic        overflow;
  logic [7:0]  miss_count;
  logic [7:0]  drop_count;

  int tests_run;
  int fails;

  dcontact_collector_if rec_if ();

  dcontact_collector #(
    .DEPTH  (8),
    .ADDR_W (3),
    .CNT_W  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_done    (in_done),
    .in_ret     (in_ret),
    .in_cx      (in_cx),
    .in_cy      (in_cy),
    .in_cz      (in_cz),
    .in_nx      (in_nx),
    .in_ny      (in_ny),
    .in_nz      (in_nz),
    .in_depth   (in_depth),
    .in_g1      (in_g1),
    .in_g2      (in_g2),
    .rec        (rec_if),
    .count      (count),
    .overflow   (overflow),
    .miss_count (miss_count),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Fields derived from a tag so every record is distinct and predictable.
  task automatic set_fields(input logic [31:0] tag);
    in_cx    = 32'h4000_0000 | tag;
    in_cy    = 32'h4100_0000 | tag;
    in_cz    = 32'h4200_0000 | tag;
    in_nx    = 32'h3F00_0000 | tag;
    in_ny    = 32'hBF00_0000 | tag;
    in_nz    = 32'h3E80_0000 | tag;
    in_depth = 32'h3D00_0000 | tag;
    in_g1    = tag;
    in_g2    = ~tag;
  endtask

  // One done rise with optional same-cycle ack; returns at a falling edge
  // after done has dropped again and done_q has followed.
  task automatic fire(input logic ret, input logic [31:0] tag, input logic ack);
    set_fields(tag);
    in_ret         = ret;
    in_done        = 1'b1;
    rec_if.out_ack = ack;
    @(negedge clk);
    in_done        = 1'b0;
    rec_if.out_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_one();
    rec_if.out_ack = 1'b1;
    @(negedge clk);
    rec_if.out_ack = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; clear = 1'b0; in_done = 1'b0; in_ret = 1'b0;
    rec_if.out_ack = 1'b0;
    set_fields(32'h0);
    repeat (2) @(negedge clk);
    tests_run++; if (rec_if.out_stb !== 1'b0) begin fails++; $display("[TB] FAIL reset_stb: got %b want 0", rec_if.out_stb); end
    tests_run++; if (count !== 4'd0) begin fails++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
    tests_run++; if ({overflow, miss_count, drop_count} !== 17'd0) begin fails++; $display("[TB] FAIL reset_status: ovf=%b miss=%0d drop=%0d want all 0", overflow, miss_count, drop_count); end
    tests_run++; if ({rec_if.out_cx, rec_if.out_depth, rec_if.out_g1, rec_if.out_g2} !== 128'd0) begin fails++; $display("[TB] FAIL reset_data: cx=%h depth=%h g1=%h g2=%h want 0", rec_if.out_cx, rec_if.out_depth, rec_if.out_g1, rec_if.out_g2); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_contact();
    in_cx = FP_ONE; in_cy = 32'h4040_0000; in_cz = 32'hC000_0000;
    in_nx = 32'h0000_0000; in_ny = FP_ONE; in_nz = 32'h8000_0000;
    in_depth = 32'h3F00_0000; in_g1 = 32'd5; in_g2 = 32'd9;
    in_ret = 1'b1;
    in_done = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++; if (rec_if.out_stb !== 1'b1) begin fails++; $display("[TB] FAIL single_stb: got %b want 1", rec_if.out_stb); end
    tests_run++; if (count !== 4'd1) begin fails++; $display("[TB] FAIL single_count: got %0d want 1", count); end
    tests_run++; if ({rec_if.out_cx, rec_if.out_cy, rec_if.out_cz} !== {FP_ONE, 32'h4040_0000, 32'hC000_0000}) begin fails++; $display("[TB] FAIL single_pos: got %h %h %h want 3f800000 40400000 c0000000", rec_if.out_cx, rec_if.out_cy, rec_if.out_cz); end
    tests_run++; if ({rec_if.out_nx, rec_if.out_ny, rec_if.out_nz} !== {32'h0, FP_ONE, 32'h8000_0000}) begin fails++; $display("[TB] FAIL single_normal: got %h %h %h want 00000000 3f800000 80000000", rec_if.out_nx, rec_if.out_ny, rec_if.out_nz); end
    tests_run++; if ({rec_if.out_depth, rec_if.out_g1, rec_if.out_g2} !== {32'h3F00_0000, 32'd5, 32'd9}) begin fails++; $display("[TB] FAIL single_depth_ids: got %h %0d %0d want 3f000000 5 9", rec_if.out_depth, rec_if.out_g1, rec_if.out_g2); end
    repeat (18) @(negedge clk);
    tests_run++; if (count !== 4'd1) begin fails++; $display("[TB] FAIL single_held_done: count %0d want 1", count); end
    pop_one();
    tests_run++; if (rec_if.out_stb !== 1'b0 || count !== 4'd0) begin fails++; $display("[TB] FAIL single_ack: stb=%b count=%0d want 0 0", rec_if.out_stb, count); end
    @(negedge clk);
    tests_run++; if (rec_if.out_cx !== FP_ONE || rec_if.out_g1 !== 32'd5) begin fails++; $display("[TB] FAIL single_empty_hold: cx=%h g1=%0d want 3f800000 5", rec_if.out_cx, rec_if.out_g1); end
    in_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_no_contact();
    for (int i = 0; i < 3; i++) fire(1'b0, 32'(100 + i), 1'b0);
    tests_run++; if (miss_count !== 8'd3) begin fails++; $display("[TB] FAIL miss_count: got %0d want 3", miss_count); end
    tests_run++; if (count !== 4'd0 || rec_if.out_stb !== 1'b0) begin fails++; $display("[TB] FAIL miss_empty: count=%0d stb=%b want 0 0", count, rec_if.out_stb); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 10; i++) fire(1'b1, 32'(i), 1'b0);
    tests_run++; if (count !== 4'd8) begin fails++; $display("[TB] FAIL fill_count: got %0d want 8", count); end
    tests_run++; if (overflow !== 1'b1) begin fails++; $display("[TB] FAIL fill_overflow: got %b want 1", overflow); end
    tests_run++; if (drop_count !== 8'd2) begin fails++; $display("[TB] FAIL fill_drop: got %0d want 2", drop_count); end
    for (int i = 0; i < 8; i++) begin
      tests_run++; if (rec_if.out_stb !== 1'b1 || rec_if.out_g1 !== 32'(i) || rec_if.out_cx !== (32'h4000_0000 | 32'(i))) begin fails++; $display("[TB] FAIL fill_drain_%0d: stb=%b g1=%0d cx=%h want 1 %0d %h", i, rec_if.out_stb, rec_if.out_g1, rec_if.out_cx, i, 32'h4000_0000 | 32'(i)); end
      pop_one();
    end
    tests_run++; if (count !== 4'd0 || rec_if.out_stb !== 1'b0) begin fails++; $display("[TB] FAIL fill_drained: count=%0d stb=%b want 0 0", count, rec_if.out_stb); end
    @(negedge clk);
    tests_run++; if (rec_if.out_g1 !== 32'd7) begin fails++; $display("[TB] FAIL fill_empty_hold: g1=%0d want 7", rec_if.out_g1); end
  endtask

  task automatic test_full_push_pop();
    pulse_clear();
    for (int i = 0; i < 8; i++) fire(1'b1, 32'(20 + i), 1'b0);
    tests_run++; if (count !== 4'd8) begin fails++; $display("[TB] FAIL pp_fill: count %0d want 8", count); end
    fire(1'b1, 32'd28, 1'b1);
    tests_run++; if (count !== 4'd8 || drop_count !== 8'd0 || overflow !== 1'b0) begin fails++; $display("[TB] FAIL pp_same_cycle: count=%0d drop=%0d ovf=%b want 8 0 0", count, drop_count, overflow); end
    for (int i = 0; i < 8; i++) begin
      tests_run++; if (rec_if.out_g1 !== 32'(21 + i) || rec_if.out_g2 !== ~32'(21 + i)) begin fails++; $display("[TB] FAIL pp_drain_%0d: g1=%0d g2=%h want %0d %h", i, rec_if.out_g1, rec_if.out_g2, 21 + i, ~32'(21 + i)); end
      pop_one();
    end
    tests_run++; if (count !== 4'd0) begin fails++; $display("[TB] FAIL pp_empty: count %0d want 0", count); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_q[$];
    for (int i = 0; i < 20; i++) begin
      fire(1'b1, 32'(40 + i), 1'b0);
      exp_q.push_back(32'(40 + i));
      tests_run++; if (count !== 4'(exp_q.size())) begin fails++; $display("[TB] FAIL wrap_count_%0d: got %0d want %0d", i, count, exp_q.size()); end
      if (exp_q.size() == 3) begin
        tests_run++; if (rec_if.out_g1 !== exp_q[0] || rec_if.out_nz !== (32'h3E80_0000 | exp_q[0])) begin fails++; $display("[TB] FAIL wrap_order_%0d: g1=%0d nz=%h want %0d %h", i, rec_if.out_g1, rec_if.out_nz, exp_q[0], 32'h3E80_0000 | exp_q[0]); end
        pop_one();
        void'(exp_q.pop_front());
      end
    end
    while (exp_q.size() != 0) begin
      tests_run++; if (rec_if.out_g1 !== exp_q[0]) begin fails++; $display("[TB] FAIL wrap_tail: g1=%0d want %0d", rec_if.out_g1, exp_q[0]); end
      pop_one();
      void'(exp_q.pop_front());
    end
    tests_run++; if (count !== 4'd0 || overflow !== 1'b0) begin fails++; $display("[TB] FAIL wrap_end: count=%0d ovf=%b want 0 0", count, overflow); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 9; i++) fire(1'b1, 32'(60 + i), 1'b0);
    fire(1'b0, 32'd69, 1'b0);
    tests_run++; if (count !== 4'd8 || overflow !== 1'b1 || drop_count !== 8'd1 || miss_count !== 8'd1) begin fails++; $display("[TB] FAIL clear_setup: count=%0d ovf=%b drop=%0d miss=%0d want 8 1 1 1", count, overflow, drop_count, miss_count); end
    set_fields(32'd70);
    in_ret  = 1'b1;
    in_done = 1'b1;
    clear   = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++; if (count !== 4'd0 || rec_if.out_stb !== 1'b0) begin fails++; $display("[TB] FAIL clear_fifo: count=%0d stb=%b want 0 0", count, rec_if.out_stb); end
    tests_run++; if ({overflow, miss_count, drop_count} !== 17'd0) begin fails++; $display("[TB] FAIL clear_status: ovf=%b miss=%0d drop=%0d want all 0", overflow, miss_count, drop_count); end
    in_done = 1'b0;
    @(negedge clk);
    fire(1'b1, 32'd71, 1'b0);
    tests_run++; if (count !== 4'd1 || rec_if.out_g1 !== 32'd71) begin fails++; $display("[TB] FAIL clear_after: count=%0d g1=%0d want 1 71", count, rec_if.out_g1); end
    pulse_clear();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) fire(1'b1, 32'(80 + i), 1'b0);
    pop_one();
    tests_run++; if (count !== 4'd3 || rec_if.out_g1 !== 32'd81) begin fails++; $display("[TB] FAIL rmid_setup: count=%0d g1=%0d want 3 81", count, rec_if.out_g1); end
    #2;
    rst = 1'b0;
    #1;
    tests_run++; if (rec_if.out_stb !== 1'b0 || count !== 4'd0) begin fails++; $display("[TB] FAIL rmid_async: stb=%b count=%0d want 0 0", rec_if.out_stb, count); end
    tests_run++; if (rec_if.out_g1 !== 32'd0 || rec_if.out_cx !== 32'd0) begin fails++; $display("[TB] FAIL rmid_data: g1=%h cx=%h want 0 0", rec_if.out_g1, rec_if.out_cx); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if (count !== 4'd0 || rec_if.out_stb !== 1'b0) begin fails++; $display("[TB] FAIL rmid_release: count=%0d stb=%b want 0 0", count, rec_if.out_stb); end
    fire(1'b1, 32'd90, 1'b0);
    tests_run++; if (count !== 4'd1 || rec_if.out_g1 !== 32'd90) begin fails++; $display("[TB] FAIL rmid_fresh: count=%0d g1=%0d want 1 90", count, rec_if.out_g1); end
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    test_reset();
    test_single_contact();
    test_no_contact();
    test_fill_overflow();
    test_full_push_pop();
    test_wrap();
    test_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
